branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage control-flow resolver for the pipelined CPU; parametrised successor to the current EX-stage branch/NOP logic.
- Evaluates conditional branches, jal, jr and exec against the flags of the previous instruction, and issues a one-cycle PC redirect.
- Squashes a configurable number of wrong-path instructions, and performs exec's one-instruction excursion and automatic return.
- Clocked and stall-aware; the squash counter and exec state are registered, not rebuilt from PC changes.

Parameters:
- PC_W, 16, PC/target width.
- FLUSH_DEPTH, 3, wrong-path instructions squashed after a redirect; range 1..7.
- CNT_W, $clog2(FLUSH_DEPTH+1), width of the squash counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_ex  in  1  an instruction occupies EX.
- stall  in  1  EX is held this cycle; no state advances.
- branch_ex  in  1  conditional branch in EX.
- jal_ex  in  1  jump-and-link in EX.
- jr_ex  in  1  jump-register in EX.
- exec_ex  in  1  exec in EX.
- cond_ex  in  4  branch condition code.
- flag_ex  in  3  flags of the previous instruction: [2]=Z, [1]=V, [0]=N.
- target_ex  in  PC_W  resolved target (PC+1+offset, or register value).
- pc_plus1_ex  in  PC_W  PC+1 of the EX instruction.
- redirect  out  1  load redirect_pc into the PC this cycle.
- redirect_pc  out  PC_W  new PC.
- put_pc_back  out  1  this redirect is an exec return.
- squash_alu  out  1  suppress ALU/register writeback of the EX instruction.
- squash_lw  out  1  suppress load of the EX instruction.
- squash_sw  out  1  suppress store of the EX instruction.
- exec_pending  out  1  exec return armed.
- squash_cnt  out  CNT_W  remaining wrong-path slots.

Behaviour:
- Reset values: squash_cnt=0, state=IDLE, exec_ret_pc=0. All outputs are 0 during and immediately after reset.
- Reset mid-flush or mid-exec abandons the operation; there is no pending return afterwards.
- An instruction is live when valid_ex=1, stall=0 and squash_cnt=0.
- Shadow instruction (valid_ex=1, squash_cnt>0):
  - squash_alu=squash_lw=squash_sw=1.
  - Its control bits are ignored; no redirect.
  - squash_cnt decrements by 1 on each non-stalled cycle.
- Bubble (valid_ex=0): the counter does not decrement.
- Condition codes (cond_eval):
  - 0 EQ: Z. 1 NE: !Z. 2 GT: !Z&!N. 3 LT: N.
  - 4 GE: Z|!N. 5 LE: N|Z. 6 OV: V. 7 ALWAYS: 1.
  - 8..15 reserved: never taken.
- Take condition for a live instruction: take = (branch_ex & cond_true) | jal_ex | jr_ex | exec_ex.
- Redirect (Mealy, same cycle) when take=1 and target_ex != pc_plus1_ex:
  - redirect=1, redirect_pc=target_ex.
  - squash_cnt <= FLUSH_DEPTH at the clock edge.
  - If take=1 but target_ex == pc_plus1_ex: no redirect, no flush.
- Not taken: no redirect, counter unchanged. The branch itself writes nothing; squash_alu is 0 and decode already gates the branch's writeback.
- State machine IDLE -> EXEC_ARMED -> IDLE:
  - IDLE, live exec_ex: exec_ret_pc <= pc_plus1_ex, state <= EXEC_ARMED, exec_pending=1. This applies even when target == pc+1; in that case there is no redirect and no flush.
  - EXEC_ARMED, first live instruction is the exec target: it executes normally (squash outputs 0).
  - Same cycle: redirect=1, redirect_pc=exec_ret_pc, put_pc_back=1, squash_cnt <= FLUSH_DEPTH, state <= IDLE.
  - Control bits of that target instruction are ignored; return has priority and exec is not nestable.
- Stall=1 freezes the counter and state. redirect and put_pc_back are 0 while stalled; they are asserted on the first non-stalled cycle.
- Squash outputs are combinational from squash_cnt and valid_ex, and are 0 when valid_ex=0.
- Arithmetic is unsigned, PC_W bits; comparison is exact equality with no wrap handling.
- Redirect_pc is 0 whenever redirect=0.

Decomposition:
- Package branch_pkg: condition-code localparams (COND_EQ..COND_ALWAYS), flag index constants (FLAG_Z=2, FLAG_V=1, FLAG_N=0), and the state encoding (IDLE, EXEC_ARMED).
- Sub-module branch_cond_eval: combinational; inputs cond and flags, output cond_true.

Test Plan:
- BEQ with flag=3'b100, cond=0, target=0x0040, pc+1=0x0011 -> redirect=1, redirect_pc=0x0040; the next 3 valid EX instructions have squash_alu/lw/sw=1; the 4th has them 0.
- BGT with flag=3'b001, cond=2 -> no redirect, squash_cnt stays 0. Repeat with cond=9 (reserved) -> not taken.
- Taken branch with target_ex == pc_plus1_ex -> no redirect, no squash. A taken branch arriving during the flush shadow -> squashed, no redirect, count continues 3->2->1->0.
- Exec at pc+1=0x0021, target 0x0080 -> redirect to 0x0080, 3 squashes, exec_pending=1. The next live instruction executes unsquashed with redirect=1, redirect_pc=0x0021, put_pc_back=1, then 3 squashes, exec_pending=0.
- Stall held 2 cycles during a flush with squash_cnt=2 -> count holds at 2. Bubbles (valid_ex=0) do not decrement. Redirect is held off until stall drops.
- rst asserted asynchronously in EXEC_ARMED with squash_cnt=2 -> all outputs 0 immediately. After release the next instruction is live and no return redirect occurs.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for the EX-stage branch resolver: condition codes, flag bit
// positions and the exec-return state encoding.
package branch_pkg;

    localparam logic [3:0] COND_EQ     = 4'd0;
    localparam logic [3:0] COND_NE     = 4'd1;
    localparam logic [3:0] COND_GT     = 4'd2;
    localparam logic [3:0] COND_LT     = 4'd3;
    localparam logic [3:0] COND_GE     = 4'd4;
    localparam logic [3:0] COND_LE     = 4'd5;
    localparam logic [3:0] COND_OV     = 4'd6;
    localparam logic [3:0] COND_ALWAYS = 4'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        EXEC_ARMED = 1'b1
    } exec_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against the Z/V/N flags
// of the previous instruction; reserved codes are never taken.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic z_s;
    logic v_s;
    logic n_s;

    assign z_s = flags[FLAG_Z];
    assign v_s = flags[FLAG_V];
    assign n_s = flags[FLAG_N];

    // Decode the condition code into a taken/not-taken decision.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ:     cond_true = z_s;
            COND_NE:     cond_true = ~z_s;
            COND_GT:     cond_true = ~z_s & ~n_s;
            COND_LT:     cond_true = n_s;
            COND_GE:     cond_true = z_s | ~n_s;
            COND_LE:     cond_true = n_s | z_s;
            COND_OV:     cond_true = v_s;
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage control-flow resolver: same-cycle PC redirect, wrong-path squash
// counter and the exec excursion/return state machine.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = $clog2(FLUSH_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ex,
    input  logic             stall,
    input  logic             branch_ex,
    input  logic             jal_ex,
    input  logic             jr_ex,
    input  logic             exec_ex,
    input  logic [3:0]       cond_ex,
    input  logic [2:0]       flag_ex,
    input  logic [PC_W-1:0]  target_ex,
    input  logic [PC_W-1:0]  pc_plus1_ex,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             put_pc_back,
    output logic             squash_alu,
    output logic             squash_lw,
    output logic             squash_sw,
    output logic             exec_pending,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH);

    exec_state_t      state_r;
    logic [PC_W-1:0]  exec_ret_pc_r;
    logic [CNT_W-1:0] squash_cnt_r;
    logic             cond_true_s;
    logic             live_s;
    logic             take_s;
    logic             shadow_s;

    branch_cond_eval u_cond_eval (
        .cond      (cond_ex),
        .flags     (flag_ex),
        .cond_true (cond_true_s)
    );

    // rst gates liveness so nothing combinational escapes while in reset.
    assign live_s   = valid_ex & ~stall & (squash_cnt_r == {CNT_W{1'b0}}) & ~rst;
    assign take_s   = (branch_ex & cond_true_s) | jal_ex | jr_ex | exec_ex;
    assign shadow_s = valid_ex & (squash_cnt_r != {CNT_W{1'b0}});

    assign squash_alu   = shadow_s;
    assign squash_lw    = shadow_s;
    assign squash_sw    = shadow_s;
    assign squash_cnt   = squash_cnt_r;
    assign exec_pending = (state_r == EXEC_ARMED);

    // Same-cycle redirect decision; a pending exec return overrides the target's own control bits.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = {PC_W{1'b0}};
        put_pc_back = 1'b0;
        if (live_s) begin
            if (state_r == EXEC_ARMED) begin
                redirect    = 1'b1;
                redirect_pc = exec_ret_pc_r;
                put_pc_back = 1'b1;
            end else if (take_s && (target_ex != pc_plus1_ex)) begin
                redirect    = 1'b1;
                redirect_pc = target_ex;
                put_pc_back = 1'b0;
            end else begin
                redirect    = 1'b0;
                redirect_pc = {PC_W{1'b0}};
                put_pc_back = 1'b0;
            end
        end else begin
            redirect    = 1'b0;
            redirect_pc = {PC_W{1'b0}};
            put_pc_back = 1'b0;
        end
    end

    // Squash counter and exec state; both freeze while EX is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_cnt_r  <= {CNT_W{1'b0}};
            state_r       <= IDLE;
            exec_ret_pc_r <= {PC_W{1'b0}};
        end else if (!stall) begin
            if (redirect) begin
                squash_cnt_r <= FLUSH_LOAD;
            end else if (shadow_s) begin
                squash_cnt_r <= squash_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                squash_cnt_r <= squash_cnt_r;
            end
            case (state_r)
                IDLE: begin
                    if (live_s && exec_ex) begin
                        exec_ret_pc_r <= pc_plus1_ex;
                        state_r       <= EXEC_ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC_ARMED: begin
                    if (live_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= EXEC_ARMED;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end else begin
            squash_cnt_r  <= squash_cnt_r;
            state_r       <= state_r;
            exec_ret_pc_r <= exec_ret_pc_r;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected output vectors are queued as
// each step is driven and popped/compared when the DUT outputs are sampled.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex, stall, branch_ex, jal_ex, jr_ex, exec_ex;
    logic [3:0]  cond_ex;
    logic [2:0]  flag_ex;
    logic [15:0] target_ex, pc_plus1_ex;
    logic        redirect, put_pc_back, squash_alu, squash_lw, squash_sw, exec_pending;
    logic [15:0] redirect_pc;
    logic [1:0]  squash_cnt;

    logic [23:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    branch_resolve_unit #(.PC_W(16), .FLUSH_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .stall(stall),
        .branch_ex(branch_ex), .jal_ex(jal_ex), .jr_ex(jr_ex), .exec_ex(exec_ex),
        .cond_ex(cond_ex), .flag_ex(flag_ex), .target_ex(target_ex),
        .pc_plus1_ex(pc_plus1_ex), .redirect(redirect), .redirect_pc(redirect_pc),
        .put_pc_back(put_pc_back), .squash_alu(squash_alu), .squash_lw(squash_lw),
        .squash_sw(squash_sw), .exec_pending(exec_pending), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    // Expected vector layout: redirect, redirect_pc, put_pc_back, squash x3, exec_pending, squash_cnt.
    function automatic logic [23:0] e(input logic rd, input logic [15:0] pc, input logic pb,
                                      input logic sq, input logic ep, input logic [1:0] cnt);
        return {rd, pc, pb, sq, sq, sq, ep, cnt};
    endfunction

    task automatic push(input string tag, input logic [23:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        logic [23:0] got;
        logic [23:0] exp;
        string       tag;
        got = {redirect, redirect_pc, put_pc_back, squash_alu, squash_lw, squash_sw,
               exec_pending, squash_cnt};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: observed %h with no expected value queued", got);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, got, exp);
            end
        end
    endtask

    // kind bits: [3]=branch [2]=jal [1]=jr [0]=exec
    task automatic step(input string tag, input logic v, input logic st, input logic [3:0] kind,
                        input logic [3:0] cond, input logic [2:0] flag,
                        input logic [15:0] tgt, input logic [15:0] pc1, input logic [23:0] exp);
        valid_ex = v;  stall = st;
        {branch_ex, jal_ex, jr_ex, exec_ex} = kind;
        cond_ex = cond; flag_ex = flag; target_ex = tgt; pc_plus1_ex = pc1;
        push(tag, exp);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow3(input string tag, input logic ep);
        step({tag, "_sh3"}, 1'b1, 1'b0, 4'b1000, 4'd7, 3'b000, 16'h0099, 16'h0050, e(1'b0, 16'h0, 1'b0, 1'b1, ep, 2'd3));
        step({tag, "_sh2"}, 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, ep, 2'd2));
        step({tag, "_sh1"}, 1'b1, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0077, 16'h0052, e(1'b0, 16'h0, 1'b0, 1'b1, ep, 2'd1));
    endtask

    initial begin
        rst = 1'b1;
        // Live-looking jal during reset must not leak a redirect.
        step("reset", 1'b1, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0040, 16'h0011, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        rst = 1'b0;

        step("beq_taken", 1'b1, 1'b0, 4'b1000, 4'd0, 3'b100, 16'h0040, 16'h0011, e(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 2'd0));
        shadow3("beq", 1'b0);
        step("beq_4th", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0012, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("bgt_not", 1'b1, 1'b0, 4'b1000, 4'd2, 3'b001, 16'h0040, 16'h0013, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("cond9", 1'b1, 1'b0, 4'b1000, 4'd9, 3'b111, 16'h0040, 16'h0014, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("eq_false", 1'b1, 1'b0, 4'b1000, 4'd0, 3'b000, 16'h0040, 16'h0015, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));

        // LT taken, then stalls and bubbles inside the flush shadow.
        step("blt_taken", 1'b1, 1'b0, 4'b1000, 4'd3, 3'b001, 16'h0030, 16'h0016, e(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 2'd0));
        step("fl_cnt3", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd3));
        step("stall_a", 1'b1, 1'b1, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2));
        step("stall_b", 1'b1, 1'b1, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2));
        step("bubble_a", 1'b0, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd2));
        step("bubble_b", 1'b0, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0066, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd2));
        step("fl_cnt2", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2));
        step("fl_cnt1", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd1));
        step("jal_stalled", 1'b1, 1'b1, 4'b0100, 4'd0, 3'b000, 16'h0070, 16'h0031, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("jal_released", 1'b1, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0070, 16'h0031, e(1'b1, 16'h0070, 1'b0, 1'b0, 1'b0, 2'd0));
        shadow3("jal", 1'b0);

        step("jal_fallthru", 1'b1, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0045, 16'h0045, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("after_fallthru", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0046, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("jr_taken", 1'b1, 1'b0, 4'b0010, 4'd0, 3'b000, 16'h0060, 16'h0047, e(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0, 2'd0));
        shadow3("jr", 1'b0);

        // Exec excursion and automatic return.
        step("exec", 1'b1, 1'b0, 4'b0001, 4'd0, 3'b000, 16'h0080, 16'h0021, e(1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 2'd0));
        shadow3("exec", 1'b1);
        step("exec_return", 1'b1, 1'b0, 4'b0100, 4'd0, 3'b000, 16'h0055, 16'h0081, e(1'b1, 16'h0021, 1'b1, 1'b0, 1'b1, 2'd0));
        shadow3("ret", 1'b0);
        step("after_return", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0022, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));

        // Asynchronous reset while armed with squash_cnt=2.
        step("exec2", 1'b1, 1'b0, 4'b0001, 4'd0, 3'b000, 16'h0090, 16'h0031, e(1'b1, 16'h0090, 1'b0, 1'b0, 1'b0, 2'd0));
        step("exec2_sh3", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0000, e(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd3));
        valid_ex = 1'b1;
        #1;
        push("pre_async_rst", e(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd2));
        check_pop();
        rst = 1'b1;
        #1;
        push("async_rst", e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        check_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_live", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0091, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));
        step("post_rst_idle", 1'b1, 1'b0, 4'b0000, 4'd0, 3'b000, 16'h0000, 16'h0092, e(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0));

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected %0d", exp_q.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
